// File: rtl/sprite_arb_pkg.sv
// Shared types and default sizing for the sprite ROM arbiter.
package sprite_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF     = 3;
    localparam int ADDR_W_DEF    = 19;
    localparam int DATA_W_DEF    = 4;
    localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/sprite_rom_arbiter_arb_pick.sv
// Circular first-set picker: scans mask from start upward with wrap and
// returns the first set bit as one-hot plus its index.
module arb_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int i;

    // Priority scan starting at 'start'; first hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        i      = 0;
        for (int k = 0; k < N; k++) begin
            i = (int'(start) + k) % N;
            if (!valid && mask[i]) begin
                valid     = 1'b1;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shared sprite ROM arbiter: grants one requester per cycle, supports
// locked bursts bounded by MAX_BURST, returns ROM data with latency 1.
// Define SPRITE_ARB_RR_EN for round-robin arbitration; the default build
// uses fixed priority (lowest index wins).
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_q
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t        state, state_nx;
    logic [IW-1:0]     owner, owner_nx;
    logic [7:0]        count, count_nx;
    logic [IW-1:0]     start;
    logic [N_REQ-1:0]  owner_oh, others, mask;
    logic [N_REQ-1:0]  win_oh, gnt_c;
    logic [IW-1:0]     win_idx;
    logic              win_vld, hold, at_max;

    assign owner_oh = N_REQ'(1) << owner;
    assign others   = req & ~owner_oh;
    // Burst still running: only the owner may be served.
    assign hold     = (state == LOCKED) && lock[owner] && (count < 8'(MAX_BURST));
    // Burst exhausted: step aside if anyone else is waiting.
    assign at_max   = (state == LOCKED) && (count == 8'(MAX_BURST));
    assign mask     = (at_max && (|others)) ? others : req;

`ifdef SPRITE_ARB_RR_EN
    logic [IW-1:0] ptr, ptr_nx;

    assign start = (int'(ptr) == N_REQ - 1) ? '0 : IW'(ptr + 1'b1);

    // Pointer follows the last winner of an open (non-held) arbitration.
    always_comb begin
        ptr_nx = ptr;
        if (!hold && win_vld) ptr_nx = win_idx;
    end

    // Round-robin pointer register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) ptr <= IW'(N_REQ - 1);
        else          ptr <= ptr_nx;
    end
`else
    assign start = '0;
`endif

    arb_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .mask   (mask),
        .start  (start),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_vld)
    );

    // Next-state and grant decode.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        count_nx = count;
        gnt_c    = '0;
        if (hold) begin
            if (req[owner]) begin
                gnt_c    = owner_oh;
                count_nx = count + 8'd1;
            end
        end else if (win_vld) begin
            gnt_c = win_oh;
            if (lock[win_idx]) begin
                state_nx = LOCKED;
                owner_nx = win_idx;
                count_nx = 8'd1;
            end else begin
                state_nx = IDLE;
                count_nx = 8'd0;
            end
        end
    end

    assign gnt = gnt_c & {N_REQ{reset_n}};

    // Route the granted requester's address to the ROM.
    always_comb begin
        rom_address = '0;
        for (int k = 0; k < N_REQ; k++)
            if (gnt[k]) rom_address = addr[k*ADDR_W +: ADDR_W];
    end

    // FSM state, owner and burst counter.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            count <= count_nx;
        end
    end

    // Read return: capture ROM data one cycle after the grant.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt;
            if (|gnt) rdata <= rom_q;
        end
    end

endmodule
